finish_unit: RTL and testbench

Client-side TileLink finish generator. Sinks grant beats from the network, forwards them to the client refill port, and for every grant that requires acknowledgement emits one finish message (header swapped, manager_xact_id echoed) toward the manager. It is the producer of the finish channel whose 2-entry network queue sits downstream. It also checks multibeat grant ordering.

---
 rtl/finish_pkg.sv | 21 ++
 rtl/finish_queue.sv | 70 +++++++
 rtl/finish_unit.sv | 138 +++++++++++++
 tb/tb_finish_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/finish_pkg.sv
// Shared types for the client-side finish generator: default widths, the
// buffered finish record and the multibeat-tracking FSM states.
package finish_pkg;

  localparam int DEF_ID_W   = 3;
  localparam int DEF_XACT_W = 4;
  localparam int DEF_BEATS  = 4;

  // One pending finish message, already header-swapped.
  typedef struct packed {
    logic [DEF_ID_W-1:0]   src;
    logic [DEF_ID_W-1:0]   dst;
    logic [DEF_XACT_W-1:0] xact_id;
  } finish_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } beat_state_t;

endpackage

// File: rtl/finish_queue.sv
// Small FIFO of pending finish messages. Full/empty come from pointer match
// plus a maybe_full bit; there is no enqueue-to-dequeue bypass.
module finish_queue
  import finish_pkg::*;
#(
  parameter int FIN_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enq_valid,
  input  finish_t                    enq_data,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output finish_t                    deq_data,
  output logic                       full,
  output logic [$clog2(FIN_DEPTH):0] count
);

  localparam int PW = (FIN_DEPTH > 1) ? $clog2(FIN_DEPTH) : 1;
  localparam int CW = $clog2(FIN_DEPTH) + 1;

  finish_t       mem [FIN_DEPTH];
  logic [PW-1:0] enq_ptr;
  logic [PW-1:0] deq_ptr;
  logic          maybe_full;
  logic          ptr_match;
  logic          empty;
  logic          do_enq;
  logic          do_deq;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    if (p == PW'(FIN_DEPTH - 1)) return '0;
    else                         return p + 1'b1;
  endfunction

  assign ptr_match = (enq_ptr == deq_ptr);
  assign full      = ptr_match & maybe_full;
  assign empty     = ptr_match & ~maybe_full;
  assign do_enq    = enq_valid & ~full;
  assign do_deq    = deq_ready & ~empty;
  assign deq_valid = ~empty;
  assign deq_data  = mem[deq_ptr];

  // Occupancy derived from the pointers, including the wrapped case.
  always_comb begin
    count = '0;
    if (full)                    count = CW'(FIN_DEPTH);
    else if (enq_ptr >= deq_ptr) count = CW'(enq_ptr - deq_ptr);
    else                         count = CW'(FIN_DEPTH) - CW'(deq_ptr) + CW'(enq_ptr);
  end

  // Pointer and maybe_full bookkeeping; cleared immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enq_ptr    <= '0;
      deq_ptr    <= '0;
      maybe_full <= 1'b0;
    end else begin
      if (do_enq) enq_ptr <= wrap_inc(enq_ptr);
      if (do_deq) deq_ptr <= wrap_inc(deq_ptr);
      if (do_enq != do_deq) maybe_full <= do_enq;
    end
  end

  // Entry storage; contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    if (do_enq) mem[enq_ptr] <= enq_data;
  end

endmodule

// File: rtl/finish_unit.sv
// Client-side finish generator: passes grant beats to the refill port,
// queues one header-swapped finish per acknowledged grant and flags
// out-of-order multibeat addr_beat sequences.
module finish_unit
  import finish_pkg::*;
#(
  parameter int BEATS     = DEF_BEATS,
  parameter int FIN_DEPTH = 2,
  parameter int ID_W      = DEF_ID_W,
  parameter int XACT_W    = DEF_XACT_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         io_grant_valid,
  output logic                         io_grant_ready,
  input  logic [ID_W-1:0]              io_grant_bits_header_src,
  input  logic [ID_W-1:0]              io_grant_bits_header_dst,
  input  logic [XACT_W-1:0]            io_grant_bits_payload_manager_xact_id,
  input  logic                         io_grant_bits_payload_has_data,
  input  logic [$clog2(BEATS)-1:0]     io_grant_bits_payload_addr_beat,
  input  logic                         io_grant_bits_payload_requires_ack,
  output logic                         io_refill_valid,
  input  logic                         io_refill_ready,
  output logic [XACT_W-1:0]            io_refill_bits_manager_xact_id,
  output logic                         io_refill_bits_has_data,
  output logic [$clog2(BEATS)-1:0]     io_refill_bits_addr_beat,
  output logic                         io_refill_bits_requires_ack,
  output logic                         io_finish_valid,
  input  logic                         io_finish_ready,
  output logic [ID_W-1:0]              io_finish_bits_header_src,
  output logic [ID_W-1:0]              io_finish_bits_header_dst,
  output logic [XACT_W-1:0]            io_finish_bits_payload_manager_xact_id,
  output logic [$clog2(FIN_DEPTH):0]   io_fin_count,
  output logic                         io_beat_error
);

  localparam int BW = $clog2(BEATS);

  beat_state_t   state;
  beat_state_t   state_n;
  logic [BW-1:0] exp_beat;
  logic [BW-1:0] exp_beat_n;
  logic          err_set;
  logic          is_last;
  logic          needs_fin;
  logic          fin_full;
  logic          pass_ok;
  logic          fire;
  finish_t       fin_in;
  finish_t       fin_head;

  assign is_last   = ~io_grant_bits_payload_has_data |
                     (io_grant_bits_payload_addr_beat == BW'(BEATS - 1));
  assign needs_fin = io_grant_bits_payload_requires_ack & is_last;
  // A grant that would need a finish waits while the buffer is full, even if
  // the buffer drains this same cycle.
  assign pass_ok   = ~needs_fin | ~fin_full;

  assign io_grant_ready  = io_refill_ready & pass_ok;
  assign io_refill_valid = io_grant_valid & pass_ok;
  assign fire            = io_grant_valid & io_grant_ready;

  assign io_refill_bits_manager_xact_id = io_grant_bits_payload_manager_xact_id;
  assign io_refill_bits_has_data        = io_grant_bits_payload_has_data;
  assign io_refill_bits_addr_beat       = io_grant_bits_payload_addr_beat;
  assign io_refill_bits_requires_ack    = io_grant_bits_payload_requires_ack;

  // The finish travels back to the manager, so src and dst swap.
  assign fin_in.src     = io_grant_bits_header_dst;
  assign fin_in.dst     = io_grant_bits_header_src;
  assign fin_in.xact_id = io_grant_bits_payload_manager_xact_id;

  finish_queue #(
    .FIN_DEPTH (FIN_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (fire & needs_fin),
    .enq_data  (fin_in),
    .deq_ready (io_finish_ready),
    .deq_valid (io_finish_valid),
    .deq_data  (fin_head),
    .full      (fin_full),
    .count     (io_fin_count)
  );

  assign io_finish_bits_header_src              = fin_head.src;
  assign io_finish_bits_header_dst              = fin_head.dst;
  assign io_finish_bits_payload_manager_xact_id = fin_head.xact_id;

  // Beat tracker state and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      exp_beat      <= '0;
      io_beat_error <= 1'b0;
    end else begin
      state    <= state_n;
      exp_beat <= exp_beat_n;
      if (err_set) io_beat_error <= 1'b1;
    end
  end

  // Next beat state: follow whatever beat actually fired, flag any deviation.
  always_comb begin
    state_n    = state;
    exp_beat_n = exp_beat;
    err_set    = 1'b0;
    if (fire) begin
      case (state)
        S_IDLE: begin
          if (io_grant_bits_payload_has_data) begin
            if (io_grant_bits_payload_addr_beat != '0) err_set = 1'b1;
            if (!is_last) begin
              state_n    = S_BURST;
              exp_beat_n = io_grant_bits_payload_addr_beat + 1'b1;
            end
          end
        end
        S_BURST: begin
          if (!io_grant_bits_payload_has_data) begin
            err_set = 1'b1;
          end else begin
            if (io_grant_bits_payload_addr_beat != exp_beat) err_set = 1'b1;
            if (is_last) begin
              state_n    = S_IDLE;
              exp_beat_n = '0;
            end else begin
              exp_beat_n = io_grant_bits_payload_addr_beat + 1'b1;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_finish_unit.sv
// Bench for finish_unit: scenario tasks drive grants, a scoreboard queue holds
// the finishes each acknowledged grant should produce.
module tb_finish_unit;

  typedef struct packed {
    logic [2:0] src;
    logic [2:0] dst;
    logic [3:0] xact;
  } fin_exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       grant_valid, grant_ready;
  logic [2:0] g_src, g_dst;
  logic [3:0] g_xact;
  logic       g_has_data;
  logic [1:0] g_beat;
  logic       g_ack;
  logic       refill_valid, refill_ready;
  logic [3:0] r_xact;
  logic       r_has_data;
  logic [1:0] r_beat;
  logic       r_ack;
  logic       finish_valid, finish_ready;
  logic [2:0] f_src, f_dst;
  logic [3:0] f_xact;
  logic [1:0] fin_count;
  logic       beat_error;

  fin_exp_t sb[$];
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  finish_unit dut (
    .clk                                   (clk),
    .reset                                 (reset),
    .io_grant_valid                        (grant_valid),
    .io_grant_ready                        (grant_ready),
    .io_grant_bits_header_src              (g_src),
    .io_grant_bits_header_dst              (g_dst),
    .io_grant_bits_payload_manager_xact_id (g_xact),
    .io_grant_bits_payload_has_data        (g_has_data),
    .io_grant_bits_payload_addr_beat       (g_beat),
    .io_grant_bits_payload_requires_ack    (g_ack),
    .io_refill_valid                       (refill_valid),
    .io_refill_ready                       (refill_ready),
    .io_refill_bits_manager_xact_id        (r_xact),
    .io_refill_bits_has_data               (r_has_data),
    .io_refill_bits_addr_beat              (r_beat),
    .io_refill_bits_requires_ack           (r_ack),
    .io_finish_valid                       (finish_valid),
    .io_finish_ready                       (finish_ready),
    .io_finish_bits_header_src             (f_src),
    .io_finish_bits_header_dst             (f_dst),
    .io_finish_bits_payload_manager_xact_id(f_xact),
    .io_fin_count                          (fin_count),
    .io_beat_error                         (beat_error)
  );

  task automatic set_beat(input logic [2:0] src, input logic [2:0] dst, input logic [3:0] xact,
                          input logic hd, input logic [1:0] beat, input logic ack);
    grant_valid = 1'b1;
    g_src = src; g_dst = dst; g_xact = xact;
    g_has_data = hd; g_beat = beat; g_ack = ack;
    #1;
  endtask

  // Advance one clock; record finishes the bench expects and score dequeues.
  task automatic tick();
    fin_exp_t got;
    if (grant_valid && grant_ready && g_ack && (!g_has_data || g_beat == 2'd3))
      sb.push_back('{src: g_dst, dst: g_src, xact: g_xact});
    if (finish_valid && finish_ready) begin
      got = '{src: f_src, dst: f_dst, xact: f_xact};
      checks++;
      if (sb.size() == 0) $display("FAIL sb_unexpected_finish got %h required none", got);
      else begin
        if (got !== sb[0]) $display("FAIL sb_finish got %h required %h", got, sb[0]);
        else passed++;
        void'(sb.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; grant_valid = 1'b1; g_src = 0; g_dst = 0; g_xact = 0;
    g_has_data = 0; g_beat = 0; g_ack = 0; refill_ready = 1'b1; finish_ready = 1'b0;
    #1;
    checks++; if (finish_valid !== 1'b0) $display("FAIL rst_finish_valid got %b required 0", finish_valid); else passed++;
    checks++; if (fin_count !== 2'd0) $display("FAIL rst_fin_count got %0d required 0", fin_count); else passed++;
    checks++; if (beat_error !== 1'b0) $display("FAIL rst_beat_error got %b required 0", beat_error); else passed++;
    checks++; if (grant_ready !== 1'b1 || refill_valid !== 1'b1)
      $display("FAIL rst_passthru got ready=%b valid=%b required 1 1", grant_ready, refill_valid); else passed++;
    grant_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_single();
    finish_ready = 1'b0;
    set_beat(3'd2, 3'd5, 4'd9, 1'b0, 2'd0, 1'b1);
    checks++; if (refill_valid !== 1'b1 || grant_ready !== 1'b1)
      $display("FAIL single_refill got valid=%b ready=%b required 1 1", refill_valid, grant_ready); else passed++;
    checks++; if (r_xact !== 4'd9 || r_ack !== 1'b1)
      $display("FAIL single_refill_bits got xact=%0d ack=%b required 9 1", r_xact, r_ack); else passed++;
    tick();
    grant_valid = 1'b0;
    #1;
    checks++; if (finish_valid !== 1'b1 || f_src !== 3'd5 || f_dst !== 3'd2 || f_xact !== 4'd9)
      $display("FAIL single_finish got v=%b src=%0d dst=%0d xact=%0d required 1 5 2 9",
               finish_valid, f_src, f_dst, f_xact); else passed++;
    checks++; if (fin_count !== 2'd1) $display("FAIL single_count got %0d required 1", fin_count); else passed++;
    finish_ready = 1'b1;
    tick();
    finish_ready = 1'b0;
    checks++; if (fin_count !== 2'd0) $display("FAIL single_drain got %0d required 0", fin_count); else passed++;
  endtask

  task automatic test_burst();
    for (int b = 0; b < 4; b++) begin
      set_beat(3'd1, 3'd3, 4'd3, 1'b1, 2'(b), 1'b1);
      tick();
      grant_valid = 1'b0;
      #1;
      if (b < 3) begin
        checks++; if (fin_count !== 2'd0) $display("FAIL burst_early_fin beat %0d got %0d required 0", b, fin_count); else passed++;
      end
    end
    checks++; if (fin_count !== 2'd1) $display("FAIL burst_one_fin got %0d required 1", fin_count); else passed++;
    checks++; if (beat_error !== 1'b0) $display("FAIL burst_error got %b required 0", beat_error); else passed++;
    // A fresh beat 0 must be accepted cleanly if the tracker returned to idle.
    set_beat(3'd1, 3'd3, 4'd4, 1'b1, 2'd0, 1'b0);
    tick();
    for (int b = 1; b < 4; b++) begin
      set_beat(3'd1, 3'd3, 4'd4, 1'b1, 2'(b), 1'b0);
      tick();
    end
    grant_valid = 1'b0;
    checks++; if (beat_error !== 1'b0) $display("FAIL burst_idle_after got %b required 0", beat_error); else passed++;
    finish_ready = 1'b1;
    tick();
    finish_ready = 1'b0;
  endtask

  task automatic test_full();
    finish_ready = 1'b0;
    set_beat(3'd0, 3'd6, 4'd1, 1'b0, 2'd0, 1'b1); tick();
    set_beat(3'd0, 3'd6, 4'd2, 1'b0, 2'd0, 1'b1); tick();
    grant_valid = 1'b0; #1;
    checks++; if (fin_count !== 2'd2) $display("FAIL full_count got %0d required 2", fin_count); else passed++;
    set_beat(3'd0, 3'd6, 4'd3, 1'b0, 2'd0, 1'b1);
    checks++; if (grant_ready !== 1'b0 || refill_valid !== 1'b0)
      $display("FAIL full_stall got ready=%b valid=%b required 0 0", grant_ready, refill_valid); else passed++;
    set_beat(3'd0, 3'd6, 4'd3, 1'b0, 2'd0, 1'b0);
    checks++; if (grant_ready !== 1'b1 || refill_valid !== 1'b1)
      $display("FAIL full_noack_pass got ready=%b valid=%b required 1 1", grant_ready, refill_valid); else passed++;
    tick();
    grant_valid = 1'b0; #1;
  endtask

  task automatic test_full_stall();
    finish_ready = 1'b1;
    set_beat(3'd4, 3'd1, 4'd7, 1'b0, 2'd0, 1'b1);
    checks++; if (grant_ready !== 1'b0) $display("FAIL stall_no_bypass got ready=%b required 0", grant_ready); else passed++;
    tick();
    checks++; if (fin_count !== 2'd1) $display("FAIL stall_dequeued got %0d required 1", fin_count); else passed++;
    checks++; if (grant_ready !== 1'b1) $display("FAIL stall_release got ready=%b required 1", grant_ready); else passed++;
    finish_ready = 1'b0;
    tick();
    grant_valid = 1'b0; #1;
    checks++; if (fin_count !== 2'd2) $display("FAIL stall_refilled got %0d required 2", fin_count); else passed++;
    finish_ready = 1'b1;
    tick(); tick();
    finish_ready = 1'b0;
    checks++; if (fin_count !== 2'd0) $display("FAIL stall_drain got %0d required 0", fin_count); else passed++;
  endtask

  task automatic test_beat_error();
    set_beat(3'd2, 3'd2, 4'd0, 1'b1, 2'd0, 1'b0); tick();
    checks++; if (beat_error !== 1'b0) $display("FAIL err_beat0 got %b required 0", beat_error); else passed++;
    set_beat(3'd2, 3'd2, 4'd0, 1'b1, 2'd2, 1'b0); tick();
    checks++; if (beat_error !== 1'b1) $display("FAIL err_skip got %b required 1", beat_error); else passed++;
    set_beat(3'd2, 3'd2, 4'd0, 1'b1, 2'd3, 1'b0); tick();
    set_beat(3'd2, 3'd2, 4'd0, 1'b0, 2'd0, 1'b0); tick();
    for (int b = 0; b < 4; b++) begin
      set_beat(3'd2, 3'd2, 4'd0, 1'b1, 2'(b), 1'b0);
      tick();
    end
    grant_valid = 1'b0; #1;
    checks++; if (beat_error !== 1'b1) $display("FAIL err_sticky got %b required 1", beat_error); else passed++;
  endtask

  task automatic test_async_reset();
    finish_ready = 1'b0;
    set_beat(3'd3, 3'd7, 4'd4, 1'b0, 2'd0, 1'b1); tick();
    set_beat(3'd3, 3'd7, 4'd5, 1'b0, 2'd0, 1'b1); tick();
    set_beat(3'd3, 3'd7, 4'd0, 1'b1, 2'd0, 1'b1); tick();
    set_beat(3'd3, 3'd7, 4'd0, 1'b1, 2'd1, 1'b1); tick();
    grant_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (finish_valid !== 1'b0 || fin_count !== 2'd0 || beat_error !== 1'b0)
      $display("FAIL async_rst got v=%b cnt=%0d err=%b required 0 0 0", finish_valid, fin_count, beat_error); else passed++;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    for (int b = 0; b < 4; b++) begin
      set_beat(3'd3, 3'd7, 4'd6, 1'b1, 2'(b), 1'b1);
      tick();
    end
    grant_valid = 1'b0; #1;
    checks++; if (beat_error !== 1'b0 || fin_count !== 2'd1)
      $display("FAIL post_rst_burst got err=%b cnt=%0d required 0 1", beat_error, fin_count); else passed++;
    finish_ready = 1'b1;
    tick();
    finish_ready = 1'b0;
    checks++; if (sb.size() != 0) $display("FAIL sb_leftover got %0d required 0", sb.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full();
    test_full_stall();
    test_beat_error();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
